// File: rtl/ana_trigger_unit.sv
// Trigger generator: value/mask compare on a registered probe bus, level/edge event
// qualification, event counting and post-match delay. Optional ANA_TRIG_TIMESTAMP_EN adds a fire timestamp.
module ana_trigger_unit #(
    parameter int DATA_WIDTH = 64,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] probe_in,
    input  logic [DATA_WIDTH-1:0] cfg_value,
    input  logic [DATA_WIDTH-1:0] cfg_mask,
    input  logic [1:0]            cfg_mode,
    input  logic [CNT_WIDTH-1:0]  cfg_count,
    input  logic [CNT_WIDTH-1:0]  cfg_delay,
    input  logic                  arm,
    input  logic                  disarm,
    output logic                  trigger,
    output logic                  armed,
    output logic                  done,
    output logic [1:0]            state,
    output logic [CNT_WIDTH-1:0]  event_cnt,
    output logic [31:0]           trig_time
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_DELAY = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                cur_state, state_n;
    logic [DATA_WIDTH-1:0] probe_q;
    logic [DATA_WIDTH-1:0] value_l, mask_l;
    logic [1:0]            mode_l;
    logic [CNT_WIDTH-1:0]  count_l, delay_l;
    logic [CNT_WIDTH-1:0]  dly_cnt, dly_n;
    logic [CNT_WIDTH-1:0]  event_cnt_n;
    logic                  prev_match, prev_valid;
    logic                  match, evt, fire, do_arm, reached;
    logic [CNT_WIDTH-1:0]  count_eff;

    assign match     = (((probe_q ^ value_l) & mask_l) == '0);
    assign count_eff = (count_l == '0) ? CNT_WIDTH'(1) : count_l;
    // Compare one bit wider so a saturated counter still satisfies the threshold.
    assign reached   = ({1'b0, event_cnt} + (CNT_WIDTH+1)'(1)) >= {1'b0, count_eff};

    always_comb begin
        evt = 1'b0;
        case (mode_l)
            2'd0: evt = match;
            2'd1: evt = prev_valid & ~prev_match & match;
            2'd2: evt = prev_valid & prev_match & ~match;
            2'd3: evt = 1'b1;
            default: evt = 1'b0;
        endcase
    end

    always_comb begin
        state_n     = cur_state;
        event_cnt_n = event_cnt;
        dly_n       = dly_cnt;
        fire        = 1'b0;
        do_arm      = 1'b0;
        if (disarm) begin
            state_n = S_IDLE;
        end else begin
            case (cur_state)
                S_IDLE, S_DONE: begin
                    if (arm) begin
                        do_arm      = 1'b1;
                        event_cnt_n = '0;
                        state_n     = S_ARMED;
                    end
                end
                S_ARMED: begin
                    if (evt) begin
                        if (event_cnt != '1) event_cnt_n = event_cnt + CNT_WIDTH'(1);
                        if (reached) begin
                            if (delay_l != '0) begin
                                state_n = S_DELAY;
                                dly_n   = delay_l;
                            end else begin
                                fire    = 1'b1;
                                state_n = S_DONE;
                            end
                        end
                    end
                end
                S_DELAY: begin
                    if (dly_cnt == CNT_WIDTH'(1)) begin
                        fire    = 1'b1;
                        state_n = S_DONE;
                    end else begin
                        dly_n = dly_cnt - CNT_WIDTH'(1);
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_state  <= S_IDLE;
            trigger    <= 1'b0;
            event_cnt  <= '0;
            dly_cnt    <= '0;
            probe_q    <= '0;
            prev_match <= 1'b0;
            prev_valid <= 1'b0;
            value_l    <= '0;
            mask_l     <= '0;
            mode_l     <= 2'd0;
            count_l    <= '0;
            delay_l    <= '0;
        end else begin
            cur_state  <= state_n;
            trigger    <= fire;
            event_cnt  <= event_cnt_n;
            dly_cnt    <= dly_n;
            probe_q    <= probe_in;
            prev_match <= match;
            if (do_arm) begin
                prev_valid <= 1'b0;
                value_l    <= cfg_value;
                mask_l     <= cfg_mask;
                mode_l     <= cfg_mode;
                count_l    <= cfg_count;
                delay_l    <= cfg_delay;
            end else if (cur_state == S_ARMED) begin
                prev_valid <= 1'b1;
            end
        end
    end

`ifdef ANA_TRIG_TIMESTAMP_EN
    logic [31:0] ts_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            ts_cnt    <= '0;
            trig_time <= '0;
        end else begin
            ts_cnt <= ts_cnt + 32'd1;
            if (fire) trig_time <= ts_cnt;
        end
    end
`else
    assign trig_time = 32'd0;
`endif

    assign state = cur_state;
    assign armed = (cur_state == S_ARMED) || (cur_state == S_DELAY);
    assign done  = (cur_state == S_DONE);

endmodule

// File: tb/tb_ana_trigger_unit.sv
// Directed bench for ana_trigger_unit: hand-computed expectations checked with immediate assertions.
module tb_ana_trigger_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] probe_in, cfg_value, cfg_mask;
    logic [1:0]  cfg_mode;
    logic [15:0] cfg_count, cfg_delay;
    logic        arm, disarm;
    logic        trigger, armed, done;
    logic [1:0]  state;
    logic [15:0] event_cnt;
    logic [31:0] trig_time;

    int errors = 0;
    int checks = 0;

    ana_trigger_unit dut (
        .clk       (clk),
        .rst       (rst),
        .probe_in  (probe_in),
        .cfg_value (cfg_value),
        .cfg_mask  (cfg_mask),
        .cfg_mode  (cfg_mode),
        .cfg_count (cfg_count),
        .cfg_delay (cfg_delay),
        .arm       (arm),
        .disarm    (disarm),
        .trigger   (trigger),
        .armed     (armed),
        .done      (done),
        .state     (state),
        .event_cnt (event_cnt),
        .trig_time (trig_time)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_arm(input logic [1:0] mode, input logic [63:0] value, input logic [63:0] mask,
                          input logic [15:0] count, input logic [15:0] delay);
        cfg_mode  = mode;
        cfg_value = value;
        cfg_mask  = mask;
        cfg_count = count;
        cfg_delay = delay;
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    initial begin
        rst = 1'b1; probe_in = '0; cfg_value = '0; cfg_mask = '0; cfg_mode = 2'd0;
        cfg_count = '0; cfg_delay = '0; arm = 1'b0; disarm = 1'b0;
        tick(); tick();
        check("rst_state", 64'(state), 64'd0);
        check("rst_trigger", 64'(trigger), 64'd0);
        check("rst_armed", 64'(armed), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_event_cnt", 64'(event_cnt), 64'd0);
        check("rst_trig_time", 64'(trig_time), 64'd0);
        rst = 1'b0;
        tick();

        // 1: level match, two-edge latency
        do_arm(2'd0, 64'h5A, 64'hFF, 16'd1, 16'd0);
        check("t1_state_armed", 64'(state), 64'd1);
        check("t1_armed", 64'(armed), 64'd1);
        probe_in = 64'h1234_0000_0000_005A;
        tick();
        check("t1_no_trig_edge_k", 64'(trigger), 64'd0);
        tick();
        check("t1_trigger", 64'(trigger), 64'd1);
        check("t1_state_done", 64'(state), 64'd3);
        check("t1_done", 64'(done), 64'd1);
        check("t1_event_cnt", 64'(event_cnt), 64'd1);
        check("t1_trig_time_off", 64'(trig_time), 64'd0);
        tick();
        check("t1_trigger_width", 64'(trigger), 64'd0);
        check("t1_done_hold", 64'(state), 64'd3);

        // 2: rising-edge mode, already matching at arm, three rising edges
        do_arm(2'd1, 64'h5A, 64'hFF, 16'd3, 16'd0);
        tick(); tick();
        check("t2_no_initial_level", 64'(event_cnt), 64'd0);
        for (int i = 0; i < 3; i++) begin
            probe_in = 64'h0; tick(); tick();
            probe_in = 64'h5A; tick(); tick();
            check("t2_event_cnt", 64'(event_cnt), 64'(i + 1));
            check("t2_trigger", 64'(trigger), (i == 2) ? 64'd1 : 64'd0);
        end
        check("t2_state_done", 64'(state), 64'd3);

        // 3: level match with delay 5
        probe_in = 64'h0; tick();
        do_arm(2'd0, 64'h5A, 64'hFF, 16'd1, 16'd5);
        probe_in = 64'h5A; tick(); tick();
        check("t3_state_delay", 64'(state), 64'd2);
        check("t3_event_cnt", 64'(event_cnt), 64'd1);
        check("t3_armed_in_delay", 64'(armed), 64'd1);
        for (int j = 1; j <= 4; j++) begin
            tick();
            check("t3_wait_state", 64'(state), 64'd2);
            check("t3_wait_trigger", 64'(trigger), 64'd0);
        end
        tick();
        check("t3_trigger_at_5", 64'(trigger), 64'd1);
        check("t3_state_done", 64'(state), 64'd3);
        tick();
        check("t3_trigger_width", 64'(trigger), 64'd0);

        // 4: disarm during delay, then arm+disarm together
        probe_in = 64'h0; tick();
        do_arm(2'd0, 64'h5A, 64'hFF, 16'd1, 16'd5);
        probe_in = 64'h5A; tick(); tick();
        check("t4_in_delay", 64'(state), 64'd2);
        tick(); tick();
        disarm = 1'b1; tick(); disarm = 1'b0;
        check("t4_idle", 64'(state), 64'd0);
        check("t4_not_armed", 64'(armed), 64'd0);
        check("t4_no_trigger", 64'(trigger), 64'd0);
        check("t4_event_cnt_kept", 64'(event_cnt), 64'd1);
        for (int j = 0; j < 5; j++) begin
            tick();
            check("t4_quiet", 64'(trigger), 64'd0);
        end
        arm = 1'b1; disarm = 1'b1; tick(); arm = 1'b0; disarm = 1'b0;
        check("t4_arm_disarm_idle", 64'(state), 64'd0);
        check("t4_arm_disarm_cnt", 64'(event_cnt), 64'd1);

        // 5: immediate mode with count 0, then re-arm with a new value
        do_arm(2'd3, 64'h0, 64'h0, 16'd0, 16'd0);
        check("t5_armed", 64'(state), 64'd1);
        tick();
        check("t5_trigger", 64'(trigger), 64'd1);
        check("t5_event_cnt", 64'(event_cnt), 64'd1);
        check("t5_done", 64'(state), 64'd3);
        do_arm(2'd0, 64'hA5, 64'hFF, 16'd1, 16'd0);
        cfg_value = 64'h5A;
        tick(); tick(); tick();
        check("t5_old_value_ignored", 64'(trigger), 64'd0);
        check("t5_still_armed", 64'(state), 64'd1);
        probe_in = 64'hA5; tick(); tick();
        check("t5_new_value_trigger", 64'(trigger), 64'd1);

        // mask 0 matches every cycle; count 2 fires on the second armed cycle
        do_arm(2'd0, 64'hFFFF, 64'h0, 16'd2, 16'd0);
        tick();
        check("m0_first_event", 64'(event_cnt), 64'd1);
        check("m0_no_trigger_yet", 64'(trigger), 64'd0);
        tick();
        check("m0_trigger", 64'(trigger), 64'd1);
        check("m0_event_cnt", 64'(event_cnt), 64'd2);

        // falling-out-of-match mode
        probe_in = 64'h5A; tick();
        do_arm(2'd2, 64'h5A, 64'hFF, 16'd1, 16'd0);
        tick(); tick();
        check("fall_no_event_on_level", 64'(state), 64'd1);
        probe_in = 64'h3C; tick(); tick();
        check("fall_trigger", 64'(trigger), 64'd1);

        // reset in the middle of a delay drops the pending trigger
        probe_in = 64'h0; tick();
        do_arm(2'd0, 64'h5A, 64'hFF, 16'd1, 16'd3);
        probe_in = 64'h5A; tick(); tick();
        check("rst_mid_in_delay", 64'(state), 64'd2);
        rst = 1'b1; tick(); rst = 1'b0;
        check("rst_mid_state", 64'(state), 64'd0);
        check("rst_mid_event_cnt", 64'(event_cnt), 64'd0);
        for (int j = 0; j < 4; j++) begin
            tick();
            check("rst_mid_no_trigger", 64'(trigger), 64'd0);
        end

        // 6: timestamp at fire 100 cycles after reset release
        rst = 1'b1; tick(); rst = 1'b0;
        probe_in = 64'h0;
        repeat (99) tick();
        do_arm(2'd3, 64'h0, 64'h0, 16'd1, 16'd0);
        tick();
        check("t6_trigger", 64'(trigger), 64'd1);
`ifdef ANA_TRIG_TIMESTAMP_EN
        check("t6_trig_time", 64'(trig_time), 64'd100);
`else
        check("t6_trig_time", 64'(trig_time), 64'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
